// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor, diff = a - b, LSB first
// One full-subtractor cell and a borrow flip-flop; results held until the next publication.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sa, sb, res, res_nx;
  logic [CW-1:0]    cnt;
  logic             bin, a_msb, b_msb;
  logic             d, bout, last, accept;

  assign d      = sa[0] ^ sb[0] ^ bin;
  assign bout   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bin);
  assign last   = (cnt == CW'(WIDTH - 1));
  assign accept = (state != RUN) && start;

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // New difference bit enters from the MSB side so the LSB ends up at bit 0.
  always_comb begin
    res_nx            = res >> 1;
    res_nx[WIDTH-1]   = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa       <= '0;
      sb       <= '0;
      res      <= '0;
      cnt      <= '0;
      bin      <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      sa    <= a;
      sb    <= b;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
      res   <= '0;
      cnt   <= '0;
      bin   <= 1'b0;
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      res <= res_nx;
      bin <= bout;
      cnt <= cnt + 1'b1;
      if (last) begin
        diff     <= res_nx;
        borrow   <= bout;
        zero     <= (res_nx == '0);
        overflow <= (a_msb != b_msb) && (res_nx[WIDTH-1] != a_msb);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor (WIDTH=8)
// Stimulus pushes expected results; a negedge monitor pops and compares on each done.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, borrow, zero, overflow;
  logic [W-1:0] diff;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;
    logic         overflow;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow),
    .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every done cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_diff", {24'd0, diff}, {24'd0, e.diff});
        chk("sb_borrow", {31'd0, borrow}, {31'd0, e.borrow});
        chk("sb_zero", {31'd0, zero}, {31'd0, e.zero});
        chk("sb_overflow", {31'd0, overflow}, {31'd0, e.overflow});
      end
    end
  end

  // Drive operands and start across one accepting edge; optionally queue the expected result.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit push,
                          input logic [W-1:0] ed, input logic eb, input logic ez, input logic eo);
    exp_t e;
    a     = av;
    b     = bv;
    start = 1'b1;
    if (push) begin
      e.diff = ed; e.borrow = eb; e.zero = ez; e.overflow = eo;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called just after the accepting edge; counts edges (including acceptance) until done.
  task automatic wait_done(input bit hold, input logic [W-1:0] hd, input logic hz);
    int n;
    n = 1;
    while (!done && n < 40) begin
      chk("busy_in_run", {31'd0, busy}, 32'd1);
      if (hold) begin
        chk("hold_diff", {24'd0, diff}, {24'd0, hd});
        chk("hold_zero", {31'd0, zero}, {31'd0, hz});
      end
      @(posedge clk); #1;
      n++;
    end
    chk("latency_edges", n, W + 1);
    chk("busy_at_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_outs", {28'd0, diff[3:0] | diff[7:4], borrow, zero, overflow}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    start_op(8'd200, 8'd55, 1, 8'h91, 0, 0, 0);  wait_done(0, '0, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    start_op(8'd55, 8'd200, 1, 8'h6F, 1, 0, 0);  wait_done(0, '0, 0);
    @(posedge clk); #1;
    start_op(8'h80, 8'h01, 1, 8'h7F, 0, 0, 1);   wait_done(0, '0, 0);
    @(posedge clk); #1;
    start_op(8'h7F, 8'hFF, 1, 8'h80, 1, 0, 1);   wait_done(0, '0, 0);
    @(posedge clk); #1;

    // Back-to-back: start held on the done cycle, previous zero result held through RUN.
    start_op(8'h5A, 8'h5A, 1, 8'h00, 0, 1, 0);   wait_done(0, '0, 0);
    start_op(8'd3, 8'd5, 1, 8'hFE, 1, 0, 0);     wait_done(1, 8'h00, 1);
    @(posedge clk); #1;

    // Start re-pulsed and operands changed mid-RUN must be ignored.
    start_op(8'd200, 8'd55, 1, 8'h91, 0, 0, 0);
    repeat (2) begin @(posedge clk); #1; end
    a = 8'h01; b = 8'h02; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 8'hFF; b = 8'hFF;
    begin
      int n;
      n = 4;
      while (!done && n < 40) begin @(posedge clk); #1; n++; end
      chk("ignore_latency", n, W + 1);
    end
    @(posedge clk); #1;

    // Asynchronous reset mid-operation: outputs clear immediately and no done follows.
    start_op(8'h12, 8'h34, 0, '0, 0, 0, 0);
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_outs", {W'(0), diff} != 0 ? 32'd1 : {29'd0, borrow, zero, overflow}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      chk("no_done_after_abort", {31'd0, done}, 32'd0);
    end
    start_op(8'd10, 8'd3, 1, 8'd7, 0, 0, 0);     wait_done(0, '0, 0);
    @(posedge clk); #1;

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
